// File: rtl/cci_mpf_prim_ram_stream_pkg.sv
// Shared types and helpers for the RAM stream reader.
// Imported by the reader top and its output FIFO.
package cci_mpf_prim_ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } t_stream_state;

  function automatic int wrap_inc(int idx, int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_ram_stream_fifo.sv
// First-word-fall-through buffer for stream read data.
// Supports simultaneous push and pop; exposes occupancy.
module cci_mpf_prim_ram_stream_fifo
  import cci_mpf_prim_ram_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp_q;
  logic [PW-1:0]    rp_q;
  logic [CW-1:0]    count_q;
  logic             full;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign rdata = mem[rp_q];

  // Storage array; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= wdata;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wp_q <= PW'(wrap_inc(int'(wp_q), DEPTH));
      if (pop)  rp_q <= PW'(wrap_inc(int'(rp_q), DEPTH));
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!reset_n) !(push && full));
  a_no_udf: assert property (
    @(posedge clk) disable iff (!reset_n) !(pop && empty));

endmodule

// File: rtl/cci_mpf_prim_ram_stream_reader.sv
// Streams a range of RAM entries out as valid/ready beats.
// Reads are credit-limited so backpressure never drops data.
module cci_mpf_prim_ram_stream_reader
  import cci_mpf_prim_ram_stream_pkg::*;
#(
  parameter int N_ENTRIES        = 32,
  parameter int N_DATA_BITS      = 64,
  parameter int RAM_READ_LATENCY = 1,
  parameter int BUF_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ram_rdy,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [$clog2(N_ENTRIES)-1:0] cmd_addr,
  input  logic [$clog2(N_ENTRIES):0]   cmd_len,
  output logic [$clog2(N_ENTRIES)-1:0] ram_addr,
  output logic                         ram_wen,
  input  logic [N_DATA_BITS-1:0]       ram_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_DATA_BITS-1:0]       out_data,
  output logic                         out_last,
  output logic                         busy
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int LW = AW + 1;
  localparam int RL = RAM_READ_LATENCY;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

  if (BUF_DEPTH < RL + 1) begin : g_bad_depth
    $fatal(1, "BUF_DEPTH must be >= RAM_READ_LATENCY+1");
  end

  t_stream_state state_q;
  t_stream_state state_nxt;

  logic [AW-1:0] addr_q;
  logic [AW-1:0] ram_addr_q;
  logic [LW-1:0] rem_q;
  logic [CW-1:0] inflight_q;
  logic [RL-1:0] pv_q;
  logic [RL-1:0] pl_q;
  logic [CW-1:0] buf_count;
  logic          buf_empty;
  logic          head_last;
  logic          issue;
  logic          issue_last;
  logic          cap;
  logic          pop;
  logic          accept;
  logic [CW:0]   credit;

  assign credit     = {1'b0, inflight_q} + {1'b0, buf_count};
  assign issue      = (state_q == ISSUE) && (rem_q != '0) &&
                      (credit < DEPTH_C);
  assign issue_last = issue && (rem_q == LW'(1));
  assign cap        = pv_q[RL-1];
  assign ram_addr   = issue ? addr_q : ram_addr_q;
  assign ram_wen    = 1'b0;
  assign out_valid  = !buf_empty;
  assign out_last   = !buf_empty && head_last;
  assign pop        = out_valid && out_ready;
  assign busy       = (state_q != IDLE);
  assign accept     = cmd_valid && cmd_ready;

  // Next-state and command handshake
  always_comb begin
    state_nxt = state_q;
    cmd_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = ram_rdy && reset_n;
        if (accept && (cmd_len != '0)) state_nxt = ISSUE;
      end
      ISSUE: if (issue_last) state_nxt = DRAIN;
      DRAIN: if (pop && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, read cursor, credit counter and latency pipe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ram_addr_q <= '0;
      rem_q      <= '0;
      inflight_q <= '0;
      pv_q       <= '0;
      pl_q       <= '0;
    end else begin
      state_q    <= state_nxt;
      ram_addr_q <= ram_addr;
      if (accept && (state_q == IDLE)) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (issue) begin
        addr_q <= AW'(wrap_inc(int'(addr_q), N_ENTRIES));
        rem_q  <= rem_q - 1'b1;
      end
      unique case ({issue, cap})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: ;
      endcase
      pv_q[0] <= issue;
      pl_q[0] <= issue_last;
      for (int i = 1; i < RL; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
    end
  end

  cci_mpf_prim_ram_stream_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (N_DATA_BITS + 1),
    .CW    (CW)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cap),
    .wdata   ({pl_q[RL-1], ram_rdata}),
    .pop     (pop),
    .rdata   ({head_last, out_data}),
    .count   (buf_count),
    .empty   (buf_empty)
  );

  a_inflight: assert property (
    @(posedge clk) disable iff (!reset_n) inflight_q <= CW'(RL));

endmodule

// File: tb/tb_cci_mpf_prim_ram_stream_reader.sv
// Scoreboard bench for the RAM stream reader.
// Models a latency-3 RAM and checks every streamed beat.
module tb_cci_mpf_prim_ram_stream_reader;
  localparam int N  = 32;
  localparam int DW = 64;
  localparam int RL = 3;
  localparam int BD = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          ram_rdy;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_addr;
  logic [5:0]    cmd_len;
  logic [4:0]    ram_addr;
  logic          ram_wen;
  logic [DW-1:0] ram_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   beats = 0;
  int   cyc = 0;
  int   prev_cyc = -1;
  int   gaps = 0;
  bit   pend_busy = 0;
  bit   bp = 0;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] rpipe [RL];

  cci_mpf_prim_ram_stream_reader #(
    .N_ENTRIES        (N),
    .N_DATA_BITS      (DW),
    .RAM_READ_LATENCY (RL),
    .BUF_DEPTH        (BD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ram_rdy   (ram_rdy),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_addr  (ram_addr),
    .ram_wen   (ram_wen),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[RL-1];

  task automatic chk(string tag, logic [DW-1:0] got,
                     logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      out_ready = bp ? !out_ready : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend_busy = 0;
      end else begin
        if (pend_busy) begin
          chk("busy_fall", busy, 0);
          pend_busy = 0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious", out_valid, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("data", out_data, e.d);
            chk("last", out_last, e.l);
            if (e.l) pend_busy = 1;
            beats++;
            if (prev_cyc >= 0 && cyc != prev_cyc + 1) gaps++;
            prev_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic send(int a, int n);
    int t = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 5'(a);
    cmd_len   = 6'(n);
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_acc", cmd_ready, 1);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = 64'(((a + i) % N) * 17);
      e.l = (i == n - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, (sb.size() != 0 || busy), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int b0;
    int t;
    logic [4:0] a0;
    for (int i = 0; i < N; i++) mem[i] = 64'(i * 17);
    reset_n   = 1'b0;
    ram_rdy   = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("ram_wen", ram_wen, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    prev_cyc = -1;
    gaps = 0;
    send(3, 4);
    @(negedge clk);
    chk("rdy_busy", cmd_ready, 0);
    wait_done("basic_done");
    chk("basic_consec", gaps, 0);

    send(30, 4);
    wait_done("wrap_done");

    bp = 1'b1;
    send(12, 16);
    wait_done("bp_done");
    bp = 1'b0;

    ram_rdy = 1'b0;
    a0 = ram_addr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 5'd5;
    cmd_len   = 6'd4;
    repeat (4) begin
      @(negedge clk);
      chk("gate_ready", cmd_ready, 0);
      chk("gate_busy", busy, 0);
      chk("gate_addr", ram_addr, a0);
    end
    cmd_valid = 1'b0;
    ram_rdy = 1'b1;
    send(9, 0);
    repeat (4) begin
      @(negedge clk);
      chk("zlen_busy", busy, 0);
      chk("zlen_valid", out_valid, 0);
    end

    b0 = beats;
    send(10, 10);
    t = 0;
    while (beats < b0 + 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reached", beats >= b0 + 5, 1);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_valid", out_valid, 0);
    chk("arst_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 0);
    chk("arst_addr", ram_addr, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    send(0, 2);
    wait_done("post_rst_done");

    send(7, 32);
    wait_done("full_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
